// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode, state and control-code constants for the multi-cycle MIPS core
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_RTYPE, C_JR, C_IMM, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_HALT, C_ILL
    } iclass_t;

    localparam logic [1:0] EXT_SIGN  = 2'd0;
    localparam logic [1:0] EXT_ZERO  = 2'd1;
    localparam logic [1:0] EXT_LUI   = 2'd2;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_SLT   = 3'd4;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    localparam logic [1:0] DST_RT    = 2'd0;
    localparam logic [1:0] DST_RD    = 2'd1;
    localparam logic [1:0] DST_RA    = 2'd2;

    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_PC4    = 2'd2;

endpackage

// File: rtl/mips_main_dec.sv
// rtl/mips_main_dec.sv - combinational opcode/funct decoder: instruction class, extender mode, ALU op
module mips_main_dec
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output logic [1:0] ext_op,
    output logic [2:0] alu_op,
    output logic       illegal
);

    always_comb begin
        iclass = C_ILL;
        ext_op = EXT_SIGN;
        alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                iclass = C_RTYPE;
                case (funct)
                    FN_ADDU: alu_op = ALU_ADD;
                    FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_JR:   iclass = C_JR;
                    default: iclass = C_ILL;
                endcase
            end
            OP_ADDIU: iclass = C_IMM;
            OP_ANDI: begin
                iclass = C_IMM;
                ext_op = EXT_ZERO;
                alu_op = ALU_AND;
            end
            OP_ORI: begin
                iclass = C_IMM;
                ext_op = EXT_ZERO;
                alu_op = ALU_OR;
            end
            // lui is encoded with rs = $0, so $0 + (imm << 16) yields the result
            OP_LUI: begin
                iclass = C_IMM;
                ext_op = EXT_LUI;
            end
            OP_LW:   iclass = C_LW;
            OP_SW:   iclass = C_SW;
            OP_BEQ: begin
                iclass = C_BEQ;
                alu_op = ALU_SUB;
            end
            OP_J:    iclass = C_J;
            OP_JAL:  iclass = C_JAL;
            OP_HALT: iclass = C_HALT;
            default: iclass = C_ILL;
        endcase
        illegal = (iclass == C_ILL);
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multi-cycle control FSM: IF/ID/EX/MEM/WB sequencing with memory-stall watchdog
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       mem_re,
    output logic       mem_we,
    output logic [1:0] pc_src,
    output logic [1:0] ext_op,
    output logic       alu_src,
    output logic [2:0] alu_op,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       halted,
    output logic       err
);

    localparam int            CW      = $clog2(MEM_WAIT_MAX + 2);
    localparam bit            WD_EN   = (MEM_WAIT_MAX != 0);
    localparam logic [CW-1:0] WD_LAST = CW'(MEM_WAIT_MAX - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] wait_cnt;
    iclass_t       iclass;
    logic [1:0]    dec_ext;
    logic [2:0]    dec_alu;
    logic          dec_ill;
    logic          stall;
    logic          wd_trip;

    mips_main_dec u_dec (
        .opcode  (opcode),
        .funct   (funct),
        .iclass  (iclass),
        .ext_op  (dec_ext),
        .alu_op  (dec_alu),
        .illegal (dec_ill)
    );

    assign stall   = ((state == S_IF) || (state == S_MEM)) && !mem_ready;
    // The stall that brings the count up to the limit is the one that trips
    assign wd_trip = WD_EN && stall && (wait_cnt == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IF;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (!WD_EN || !stall || (state_nxt != state)) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        pc_src     = PC_PLUS4;
        ext_op     = EXT_SIGN;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        reg_dst    = DST_RT;
        mem_to_reg = WB_ALU;
        halted     = 1'b0;
        err        = 1'b0;
        // Gating on rst_n drops every enable the moment reset is asserted
        if (rst_n) begin
            if ((state == S_ID) || (state == S_EX) || (state == S_MEM) || (state == S_WB)) begin
                ext_op  = dec_ext;
                alu_op  = dec_alu;
                alu_src = (iclass == C_IMM) || (iclass == C_LW) || (iclass == C_SW);
                case (iclass)
                    C_RTYPE: reg_dst = DST_RD;
                    C_JAL:   reg_dst = DST_RA;
                    default: reg_dst = DST_RT;
                endcase
                case (iclass)
                    C_LW:    mem_to_reg = WB_MEM;
                    C_JAL:   mem_to_reg = WB_PC4;
                    default: mem_to_reg = WB_ALU;
                endcase
            end
            case (state)
                S_IF: begin
                    mem_re = 1'b1;
                    if (mem_ready) begin
                        ir_we     = 1'b1;
                        pc_we     = 1'b1;
                        state_nxt = S_ID;
                    end else if (wd_trip) begin
                        state_nxt = S_ERR;
                    end
                end
                S_ID: begin
                    if (dec_ill) begin
                        state_nxt = S_ERR;
                    end else if (iclass == C_HALT) begin
                        state_nxt = S_HALT;
                    end else begin
                        state_nxt = S_EX;
                    end
                end
                S_EX: begin
                    case (iclass)
                        C_BEQ: begin
                            pc_we     = zero;
                            pc_src    = PC_BRANCH;
                            state_nxt = S_IF;
                        end
                        C_J: begin
                            pc_we     = 1'b1;
                            pc_src    = PC_JUMP;
                            state_nxt = S_IF;
                        end
                        C_JAL: begin
                            pc_we     = 1'b1;
                            pc_src    = PC_JUMP;
                            reg_we    = 1'b1;
                            state_nxt = S_IF;
                        end
                        C_JR: begin
                            pc_we     = 1'b1;
                            pc_src    = PC_REG;
                            state_nxt = S_IF;
                        end
                        C_LW, C_SW: state_nxt = S_MEM;
                        default:    state_nxt = S_WB;
                    endcase
                end
                S_MEM: begin
                    mem_re = (iclass == C_LW);
                    mem_we = (iclass == C_SW);
                    if (mem_ready) begin
                        state_nxt = (iclass == C_LW) ? S_WB : S_IF;
                    end else if (wd_trip) begin
                        state_nxt = S_ERR;
                    end
                end
                S_WB: begin
                    reg_we    = 1'b1;
                    state_nxt = S_IF;
                end
                S_HALT:  halted    = 1'b1;
                S_ERR:   err       = 1'b1;
                default: state_nxt = S_ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - directed self-checking bench for mips_mc_ctrl
module tb_mips_mc_ctrl;
    import mips_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       pc_we, ir_we, reg_we, mem_re, mem_we, alu_src, halted, err;
    logic [1:0] pc_src, ext_op, reg_dst, mem_to_reg;
    logic [2:0] alu_op;

    logic       rst_n_b, zero_b, mem_ready_b;
    logic [5:0] opcode_b, funct_b;
    logic       pc_we_b, ir_we_b, reg_we_b, mem_re_b, mem_we_b, alu_src_b, halted_b, err_b;
    logic [1:0] pc_src_b, ext_op_b, reg_dst_b, mem_to_reg_b;
    logic [2:0] alu_op_b;

    int checks   = 0;
    int failures = 0;

    logic [4:0]  en_a, en_b;
    logic [18:0] all_a, all_b;
    assign en_a  = {pc_we, ir_we, reg_we, mem_re, mem_we};
    assign en_b  = {pc_we_b, ir_we_b, reg_we_b, mem_re_b, mem_we_b};
    assign all_a = {en_a, pc_src, ext_op, alu_src, alu_op, reg_dst, mem_to_reg, halted, err};
    assign all_b = {en_b, pc_src_b, ext_op_b, alu_src_b, alu_op_b, reg_dst_b, mem_to_reg_b, halted_b, err_b};

    mips_mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we),
        .mem_re(mem_re), .mem_we(mem_we), .pc_src(pc_src), .ext_op(ext_op),
        .alu_src(alu_src), .alu_op(alu_op), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .halted(halted), .err(err)
    );

    mips_mc_ctrl #(.MEM_WAIT_MAX(3)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .opcode(opcode_b), .funct(funct_b), .zero(zero_b),
        .mem_ready(mem_ready_b), .pc_we(pc_we_b), .ir_we(ir_we_b), .reg_we(reg_we_b),
        .mem_re(mem_re_b), .mem_we(mem_we_b), .pc_src(pc_src_b), .ext_op(ext_op_b),
        .alu_src(alu_src_b), .alu_op(alu_op_b), .reg_dst(reg_dst_b),
        .mem_to_reg(mem_to_reg_b), .halted(halted_b), .err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_a(input string tag, input state_t st, input logic [4:0] en);
        chk({tag, ".state"}, 32'(dut.state), 32'(st));
        chk({tag, ".en"}, 32'(en_a), 32'(en));
    endtask

    task automatic chk_b(input string tag, input state_t st, input logic [4:0] en);
        chk({tag, ".state"}, 32'(dut_b.state), 32'(st));
        chk({tag, ".en"}, 32'(en_b), 32'(en));
    endtask

    initial begin
        rst_n = 1'b0; zero = 1'b0; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h00;
        rst_n_b = 1'b0; zero_b = 1'b0; mem_ready_b = 1'b0; opcode_b = 6'h00; funct_b = 6'h00;
        #3;
        chk("reset.outs", 32'(all_a), 32'd0);
        chk_a("reset", S_IF, 5'b00000);

        // ori $1,$0,0xFFFF, zero-wait
        tick(); rst_n = 1'b1; opcode = OP_ORI; funct = 6'h3F; mem_ready = 1'b1; settle();
        chk_a("ori.if", S_IF, 5'b11010);
        chk("ori.if.pc_src", 32'(pc_src), 32'(PC_PLUS4));
        tick(); settle();
        chk_a("ori.id", S_ID, 5'b00000);
        chk("ori.id.ext_op", 32'(ext_op), 32'd1);
        tick(); settle();
        chk_a("ori.ex", S_EX, 5'b00000);
        chk("ori.ex.alu_op", 32'(alu_op), 32'd3);
        chk("ori.ex.ext_op", 32'(ext_op), 32'd1);
        chk("ori.ex.alu_src", 32'(alu_src), 32'd1);
        tick(); settle();
        chk_a("ori.wb", S_WB, 5'b00100);
        chk("ori.wb.reg_dst", 32'(reg_dst), 32'd0);

        // lw with three MEM stall cycles
        tick(); opcode = OP_LW; settle();
        chk_a("lw.if", S_IF, 5'b11010);
        tick(); settle();
        chk_a("lw.id", S_ID, 5'b00000);
        chk("lw.id.ext_op", 32'(ext_op), 32'd0);
        tick(); settle();
        chk_a("lw.ex", S_EX, 5'b00000);
        chk("lw.ex.alu_op", 32'(alu_op), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(); mem_ready = (i == 3); settle();
            chk_a($sformatf("lw.mem%0d", i), S_MEM, 5'b00010);
        end
        tick(); settle();
        chk_a("lw.wb", S_WB, 5'b00100);
        chk("lw.wb.mem_to_reg", 32'(mem_to_reg), 32'd1);

        // beq taken, then not taken
        tick(); opcode = OP_BEQ; zero = 1'b1; settle();
        chk_a("beq1.if", S_IF, 5'b11010);
        tick(); settle();
        chk_a("beq1.id", S_ID, 5'b00000);
        tick(); settle();
        chk_a("beq1.ex", S_EX, 5'b10000);
        chk("beq1.ex.pc_src", 32'(pc_src), 32'd1);
        chk("beq1.ex.alu_op", 32'(alu_op), 32'd1);
        tick(); zero = 1'b0; settle();
        chk_a("beq0.if", S_IF, 5'b11010);
        tick(); settle();
        chk_a("beq0.id", S_ID, 5'b00000);
        tick(); settle();
        chk_a("beq0.ex", S_EX, 5'b00000);

        // jal
        tick(); opcode = OP_JAL; settle();
        chk_a("jal.if", S_IF, 5'b11010);
        tick(); settle();
        chk_a("jal.id", S_ID, 5'b00000);
        tick(); settle();
        chk_a("jal.ex", S_EX, 5'b10100);
        chk("jal.ex.reg_dst", 32'(reg_dst), 32'd2);
        chk("jal.ex.mem_to_reg", 32'(mem_to_reg), 32'd2);
        chk("jal.ex.pc_src", 32'(pc_src), 32'd2);

        // halt is sticky
        tick(); opcode = OP_HALT; settle();
        chk_a("halt.if", S_IF, 5'b11010);
        tick(); settle();
        chk_a("halt.id", S_ID, 5'b00000);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_a($sformatf("halt.hold%0d", i), S_HALT, 5'b00000);
            chk($sformatf("halt.flags%0d", i), 32'({halted, err}), 32'b10);
        end

        // illegal opcode is sticky
        rst_n = 1'b0; settle();
        chk("rst2.outs", 32'(all_a), 32'd0);
        tick(); rst_n = 1'b1; opcode = 6'h3E; settle();
        chk_a("ill.if", S_IF, 5'b11010);
        tick(); settle();
        chk_a("ill.id", S_ID, 5'b00000);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_a($sformatf("err.hold%0d", i), S_ERR, 5'b00000);
            chk($sformatf("err.flags%0d", i), 32'({halted, err}), 32'b01);
        end

        // watchdog limit 3 with fetch ready stuck low
        rst_n_b = 1'b1; mem_ready_b = 1'b0; settle();
        chk_b("wd.if0", S_IF, 5'b00010);
        tick(); settle();
        chk_b("wd.if1", S_IF, 5'b00010);
        tick(); settle();
        chk_b("wd.if2", S_IF, 5'b00010);
        tick(); settle();
        chk_b("wd.err", S_ERR, 5'b00000);
        chk("wd.err.flag", 32'(err_b), 32'd1);

        // reset asserted in the middle of a stalled sw
        rst_n_b = 1'b0; settle();
        chk("wd.rst.outs", 32'(all_b), 32'd0);
        tick(); rst_n_b = 1'b1; opcode_b = OP_SW; mem_ready_b = 1'b1; settle();
        chk_b("sw.if", S_IF, 5'b11010);
        tick(); settle();
        chk_b("sw.id", S_ID, 5'b00000);
        tick(); settle();
        chk_b("sw.ex", S_EX, 5'b00000);
        chk("sw.ex.alu_src", 32'(alu_src_b), 32'd1);
        tick(); mem_ready_b = 1'b0; settle();
        chk_b("sw.mem0", S_MEM, 5'b00001);
        tick(); settle();
        chk_b("sw.mem1", S_MEM, 5'b00001);
        #1; rst_n_b = 1'b0; #1;
        chk("sw.rst.mem_we", 32'(mem_we_b), 32'd0);
        chk_b("sw.rst", S_IF, 5'b00000);
        tick(); rst_n_b = 1'b1; mem_ready_b = 1'b1; settle();
        chk_b("sw.after", S_IF, 5'b11010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control unit for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states. Drives the datapath write enables, mux selects, ALU operation and immediate-extension mode (sign, zero or lui). Stalls on a single ready handshake shared by instruction and data memory. Sits between the instruction register and the datapath; the sign/zero extender, ALU, register file and PC consume its outputs.

## Interface
Parameters:
- `MEM_WAIT_MAX`, 15: stall-cycle limit per memory access before the error state is entered; 0 disables the watchdog.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]; valid from ID onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, sampled in EX.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_we`, `ir_we`, `reg_we`, `mem_re`, `mem_we` out 1: datapath enables.
- `pc_src` out 2: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = register (jr).
- `ext_op` out 2: 0 = sign-extend, 1 = zero-extend, 2 = imm<<16.
- `alu_src` out 1: 0 = rt, 1 = extended immediate.
- `alu_op` out 3: 0 = add, 1 = sub, 2 = and, 3 = or, 4 = slt.
- `reg_dst` out 2: 0 = rt, 1 = rd, 2 = $31.
- `mem_to_reg` out 2: 0 = ALU, 1 = memory, 2 = PC+4.
- `halted` out 1: halt instruction retired.
- `err` out 1: illegal instruction or memory watchdog timeout.

## Operation
- States: IF, ID, EX, MEM, WB, HALT, ERR. The state register uses binary encoding.
- Reset values: state = IF; every output and the wait counter are 0.
- Supported instructions and their paths:
  - R-type (addu, subu, and, or, slt): IF → ID → EX → WB.
  - jr: IF → ID → EX.
  - addiu, andi, ori, lui: IF → ID → EX → WB.
  - lw: IF → ID → EX → MEM → WB.
  - sw: IF → ID → EX → MEM.
  - beq, j, jal: IF → ID → EX.
  - halt (opcode 6'h3F): IF → ID → HALT.
- IF:
  - `mem_re` = 1.
  - Holds until `mem_ready`.
  - In the ready cycle, `ir_we` = 1 and `pc_we` = 1 with `pc_src` = 0, then the state moves to ID.
- ID:
  - Decodes the instruction. An illegal opcode or funct goes to ERR.
  - `ext_op` is driven from ID through WB: 0 for addiu, lw, sw and beq; 1 for andi and ori; 2 for lui.
- EX:
  - beq: `pc_we` = `zero`, `pc_src` = 1.
  - j: `pc_we` = 1, `pc_src` = 2.
  - jal: `pc_we` = 1, `pc_src` = 2, plus `reg_we` = 1 with `reg_dst` = 2 and `mem_to_reg` = 2.
  - jr: `pc_we` = 1, `pc_src` = 3.
  - Control-flow instructions then return to IF.
- MEM:
  - lw: `mem_re` = 1. sw: `mem_we` = 1.
  - Holds until `mem_ready`.
  - `mem_we` must stay asserted and stable while stalled.
- WB: `reg_we` = 1 for exactly one cycle, then the state returns to IF.
- HALT and ERR are sticky until `rst_n` is asserted. All enables are 0 in both states. `halted` is 1 in HALT; `err` is 1 in ERR.
- Watchdog: the wait counter counts stalled cycles in IF or MEM and clears on `mem_ready` or a state change. When it reaches `MEM_WAIT_MAX` without ready, the next state is ERR.
- Reset mid-access: all enables drop asynchronously, and the PC and register file receive no write.

## Timing
- Outputs are Moore-decoded from state, `opcode` and `funct`. The only exceptions are the `mem_ready`-qualified `ir_we`/`pc_we` in IF and the `zero`-qualified `pc_we` in EX.
- Zero-wait CPI: R/imm 4, lw 5, sw 4, beq/j/jal/jr 3.
- Each stall cycle adds exactly one cycle.
- `mem_ready` outside IF and MEM is ignored.

## Structure
- Shared package `mips_pkg` holds:
  - opcode and funct constants;
  - state encoding;
  - `ext_op`, `alu_op`, `pc_src`, `reg_dst` and `mem_to_reg` codes.
  The datapath muxes and the extender select use the same constants.
- One combinational sub-module, `mips_main_dec`, maps opcode and funct to an instruction class, `ext_op`, `alu_op` and an illegal flag. The FSM stays in `mips_mc_ctrl`.

## Test plan
- ori $1,$0,0xFFFF with `mem_ready` tied 1: states IF, ID, EX, WB in 4 cycles; `ext_op` = 1, `alu_op` = 3, `reg_we` high only in WB.
- lw with `mem_ready` low for 3 cycles in MEM: `mem_re` held for 4 cycles, 8 cycles total; `ext_op` = 0; `mem_to_reg` = 1 in WB.
- beq with `zero` = 1, then again with `zero` = 0: `pc_we` pulses in EX with `pc_src` = 1 only in the first case; both take 3 cycles.
- jal: in EX, `reg_dst` = 2, `mem_to_reg` = 2, `reg_we` = 1 and `pc_src` = 2.
- Opcode 6'h3F → HALT with `halted` = 1; opcode 6'h3E → ERR with `err` = 1. Both hold for 20 cycles with all enables 0.
- `MEM_WAIT_MAX` = 3 with `mem_ready` stuck low in IF → ERR after 3 stall cycles. Then pulse `rst_n` low mid-sw in MEM → `mem_we` drops immediately and the state is IF.
